// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-to-1 registered multiplexer with valid/ready handshakes.
// Selects one input channel either from an external selector (mode=0) or
// by round-robin starting at rr_ptr (mode=1), and captures the granted
// word into a single output register whenever that register can load.
module mux_rr_nx1 #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*WIDTH-1:0]   data_in,
    input  logic [NUM_CH-1:0]         valid_in,
    output logic [NUM_CH-1:0]         ready_in,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          selector,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [SEL_W-1:0]          grant_id
);

    logic             load;
    logic             cand_valid;
    logic [SEL_W-1:0] sel_ch;
    logic [WIDTH-1:0] cand_data;
    logic [SEL_W-1:0] rr_ptr;
    logic             xfer;

    // Output register may take a new word when empty or being drained.
    assign load = !valid_out || ready_out;
    assign xfer = load && cand_valid;

    // Candidate channel selection: explicit selector or rotating priority scan.
    // Loops compare against loop indices rather than indexing with the
    // selector so out-of-range selectors simply yield no candidate.
    always_comb begin
        sel_ch     = '0;
        cand_valid = 1'b0;
        if (!mode) begin
            sel_ch = selector;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (32'(selector) == i) begin
                    cand_valid = valid_in[i];
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (!cand_valid && valid_in[i] &&
                        ((32'(rr_ptr) + k == i) || (32'(rr_ptr) + k == i + NUM_CH))) begin
                        cand_valid = 1'b1;
                        sel_ch     = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Data path for the selected channel.
    always_comb begin
        cand_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(sel_ch) == i) begin
                cand_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot grant back to the sources, suppressed while reset is asserted.
    always_comb begin
        ready_in = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ready_in[i] = reset && load && cand_valid && (32'(sel_ch) == i);
        end
    end

    // Output register: capture on load, hold data/grant when nothing is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            grant_id  <= '0;
        end else if (load) begin
            valid_out <= cand_valid;
            if (cand_valid) begin
                data_out <= cand_data;
                grant_id <= sel_ch;
            end
        end
    end

    // Round-robin pointer advances past the granted channel, wrapping at NUM_CH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (mode && xfer) begin
            if (sel_ch == SEL_W'(NUM_CH - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= sel_ch + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed self-checking bench for mux_rr_nx1 (4-channel and 3-channel instances).
module tb_mux_rr_nx1;

    logic        clk;
    logic        reset;

    logic [31:0] data_in;
    logic [3:0]  valid_in;
    logic [3:0]  ready_in;
    logic        mode;
    logic [1:0]  selector;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_out;
    logic [1:0]  grant_id;

    logic [23:0] data_in3;
    logic [2:0]  valid_in3;
    logic [2:0]  ready_in3;
    logic        mode3;
    logic [1:0]  selector3;
    logic [7:0]  data_out3;
    logic        valid_out3;
    logic        ready_out3;
    logic [1:0]  grant_id3;

    int checks = 0;
    int errors = 0;

    mux_rr_nx1 #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) dut4 (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in), .mode(mode), .selector(selector),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
        .grant_id(grant_id)
    );

    mux_rr_nx1 #(.WIDTH(8), .NUM_CH(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset), .data_in(data_in3), .valid_in(valid_in3),
        .ready_in(ready_in3), .mode(mode3), .selector(selector3),
        .data_out(data_out3), .valid_out(valid_out3), .ready_out(ready_out3),
        .grant_id(grant_id3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic out4(input string tag, input logic [7:0] d, input logic v, input logic [1:0] g);
        check({tag, "_data"},  32'(data_out),  32'(d));
        check({tag, "_valid"}, 32'(valid_out), 32'(v));
        check({tag, "_grant"}, 32'(grant_id),  32'(g));
    endtask

    initial begin
        reset      = 1'b0;
        data_in    = {8'h13, 8'h12, 8'h11, 8'h10};
        valid_in   = 4'b1111;
        mode       = 1'b1;
        selector   = 2'd0;
        ready_out  = 1'b1;
        data_in3   = {8'h22, 8'h21, 8'h20};
        valid_in3  = 3'b000;
        mode3      = 1'b1;
        selector3  = 2'd0;
        ready_out3 = 1'b1;

        // Held in reset with all inputs valid.
        step(); step(); step();
        out4("rst", 8'h00, 1'b0, 2'd0);
        check("rst_ready_in", 32'(ready_in), 32'h0);

        // Release: round-robin from ch0 with all channels valid.
        reset = 1'b1;
        #1;
        check("rel_ready_in", 32'(ready_in), 32'b0001);
        step(); out4("rr0", 8'h10, 1'b1, 2'd0);
        step(); out4("rr1", 8'h11, 1'b1, 2'd1);
        step(); out4("rr2", 8'h12, 1'b1, 2'd2);
        step(); out4("rr3", 8'h13, 1'b1, 2'd3);
        step(); out4("rr4", 8'h10, 1'b1, 2'd0);

        // Mid-stream async reset drops the registered word immediately.
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(valid_out), 32'h0);
        check("midrst_data", 32'(data_out), 32'h0);
        check("midrst_ready_in", 32'(ready_in), 32'h0);
        step();
        reset = 1'b1;
        #1;
        check("rel2_ready_in", 32'(ready_in), 32'b0001);
        step(); out4("rel2", 8'h10, 1'b1, 2'd0);
        step(); out4("pre_bp", 8'h11, 1'b1, 2'd1);

        // Backpressure holds the output and withholds grants.
        ready_out = 1'b0;
        #1;
        check("bp_ready_in", 32'(ready_in), 32'h0);
        step(); out4("bp1", 8'h11, 1'b1, 2'd1);
        step(); out4("bp2", 8'h11, 1'b1, 2'd1);
        step(); out4("bp3", 8'h11, 1'b1, 2'd1);
        check("bp3_ready_in", 32'(ready_in), 32'h0);
        ready_out = 1'b1;
        #1;
        check("bp_rel_ready_in", 32'(ready_in), 32'b0100);
        step(); out4("bp_rel", 8'h12, 1'b1, 2'd2);

        // External selector mode.
        mode     = 1'b0;
        selector = 2'd2;
        valid_in = 4'b0100;
        data_in  = {8'h13, 8'hA5, 8'h11, 8'h10};
        #1;
        check("sel_ready_in", 32'(ready_in), 32'b0100);
        step(); out4("sel", 8'hA5, 1'b1, 2'd2);

        // Selector on an idle channel: no grant, output goes invalid, data/grant hold.
        selector = 2'd1;
        valid_in = 4'b1101;
        #1;
        check("idle_ready_in", 32'(ready_in), 32'h0);
        step(); out4("idle", 8'hA5, 1'b0, 2'd2);

        // Sparse round-robin: first park rr_ptr at 1 via a ch0 grant.
        mode     = 1'b1;
        data_in  = {8'h13, 8'h12, 8'h11, 8'h10};
        valid_in = 4'b0001;
        step(); out4("park", 8'h10, 1'b1, 2'd0);
        valid_in = 4'b1001;
        #1;
        check("sparse_ready_in", 32'(ready_in), 32'b1000);
        step(); out4("sp0", 8'h13, 1'b1, 2'd3);
        step(); out4("sp1", 8'h10, 1'b1, 2'd0);
        step(); out4("sp2", 8'h13, 1'b1, 2'd3);
        step(); out4("sp3", 8'h10, 1'b1, 2'd0);

        // Three-channel instance: wrap from ch2 back to ch0.
        valid_in  = 4'b0000;
        valid_in3 = 3'b111;
        #1;
        check("n3_ready_in", 32'(ready_in3), 32'b001);
        step();
        check("n3_g0", 32'(grant_id3), 32'd0);
        check("n3_d0", 32'(data_out3), 32'h20);
        step();
        check("n3_g1", 32'(grant_id3), 32'd1);
        check("n3_d1", 32'(data_out3), 32'h21);
        step();
        check("n3_g2", 32'(grant_id3), 32'd2);
        check("n3_d2", 32'(data_out3), 32'h22);
        step();
        check("n3_g3", 32'(grant_id3), 32'd0);
        check("n3_d3", 32'(data_out3), 32'h20);
        check("n3_v3", 32'(valid_out3), 32'd1);

        // Out-of-range selector on the three-channel instance yields no grant.
        mode3     = 1'b0;
        selector3 = 2'd3;
        #1;
        check("n3_oor_ready_in", 32'(ready_in3), 32'h0);
        step();
        check("n3_oor_valid", 32'(valid_out3), 32'd0);
        check("n3_oor_data", 32'(data_out3), 32'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
